arcade_input_mapper: RTL and testbench

Parametrised player-input front end for the arcade cores. It merges the PS/2 keyboard event stream and the per-player MiSTer joystick words into registered, active-low control vectors. It shapes each coin source into a fixed-length pulse with a lockout gap, and supports upright (shared) and cocktail (separate) cabinet modes. It sits between hps_io and the game core's input ports, replacing the ad-hoc key/joystick OR logic in each top level.

---
 rtl/arcade_input_mapper_if.sv | 24 ++
 rtl/arcade_input_mapper.sv | 228 ++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mapper_if.sv
// Player-input bundle between hps_io-side sources and the arcade_input_mapper.
// The mapper takes the slave view; the environment that drives keys and joysticks takes the master view.
interface arcade_input_mapper_if #(
    parameter int NPLAYER = 2,
    parameter int NBTN    = 2
);
    logic [10:0]                 ps2_key;
    logic [NPLAYER*16-1:0]       joy;
    logic                        cabinet;
    logic [NPLAYER*(4+NBTN)-1:0] p_ctl_n;
    logic [NPLAYER-1:0]          start_n;
    logic [NPLAYER-1:0]          coin_n;
    logic                        coin_any_n;

    modport master (
        output ps2_key, joy, cabinet,
        input  p_ctl_n, start_n, coin_n, coin_any_n
    );

    modport slave (
        input  ps2_key, joy, cabinet,
        output p_ctl_n, start_n, coin_n, coin_any_n
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and MiSTer joystick words into registered active-low player controls,
// with per-player coin pulse shaping (fixed pulse, then lockout gap) and upright/cocktail merging.
module arcade_input_mapper #(
    parameter int          NPLAYER    = 2,
    parameter int          NBTN       = 2,
    parameter logic [15:0] COIN_PULSE = 16'd4800,
    parameter logic [15:0] COIN_GAP   = 16'd9600
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_input_mapper_if.slave  bus
);
    localparam int FW      = 4 + NBTN;
    localparam int NKEY    = 30;
    localparam int K_START = 20;
    localparam int K_COIN  = 24;
    localparam int K_F1    = 28;
    localparam int K_F2    = 29;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} coin_state_t;

    // Key bank layout: per keyboard player a 10-bit block {btn5..btn0, right, left, down, up},
    // then starts 1-4, coins 1-4, F1, F2.
    function automatic logic [NKEY-1:0] key_decode(input logic ext, input logic [7:0] code);
        logic [NKEY-1:0] hit;
        hit = '0;
        case (code)
            8'h75: hit[0] = 1'b1;
            8'h72: hit[1] = 1'b1;
            8'h6B: hit[2] = 1'b1;
            8'h74: hit[3] = 1'b1;
            default: ;
        endcase
        if (!ext) begin
            case (code)
                8'h29: hit[4]  = 1'b1;
                8'h14: hit[5]  = 1'b1;
                8'h11: hit[6]  = 1'b1;
                8'h12: hit[7]  = 1'b1;
                8'h1A: hit[8]  = 1'b1;
                8'h22: hit[9]  = 1'b1;
                8'h2D: hit[10] = 1'b1;
                8'h2B: hit[11] = 1'b1;
                8'h23: hit[12] = 1'b1;
                8'h34: hit[13] = 1'b1;
                8'h1C: hit[14] = 1'b1;
                8'h1B: hit[15] = 1'b1;
                8'h15: hit[16] = 1'b1;
                8'h1D: hit[17] = 1'b1;
                8'h24: hit[18] = 1'b1;
                8'h2C: hit[19] = 1'b1;
                8'h16: hit[20] = 1'b1;
                8'h1E: hit[21] = 1'b1;
                8'h26: hit[22] = 1'b1;
                8'h25: hit[23] = 1'b1;
                8'h2E: hit[24] = 1'b1;
                8'h36: hit[25] = 1'b1;
                8'h3D: hit[26] = 1'b1;
                8'h3E: hit[27] = 1'b1;
                8'h05: hit[28] = 1'b1;
                8'h06: hit[29] = 1'b1;
                default: ;
            endcase
        end
        return hit;
    endfunction

    logic              toggle_p0;
    logic [NKEY-1:0]   key_hit;
    logic [NKEY-1:0]   key_bank_p1;

    assign key_hit = key_decode(bus.ps2_key[8], bus.ps2_key[7:0]);

    // Stage 1: key event capture
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_p0   <= 1'b0;
            key_bank_p1 <= '0;
        end else begin
            toggle_p0 <= bus.ps2_key[10];
            if (bus.ps2_key[10] != toggle_p0)
                key_bank_p1 <= (key_bank_p1 & ~key_hit) | (key_hit & {NKEY{bus.ps2_key[9]}});
        end
    end

    logic [FW-1:0]      own_ctl [NPLAYER];
    logic [FW-1:0]      p2_ctl;
    logic [NPLAYER-1:0] start_own;
    logic [NPLAYER-1:0] joy_start;
    logic [NPLAYER-1:0] coin_raw;

    for (genvar p = 0; p < NPLAYER; p++) begin : g_player
        logic [FW-1:0] key_ctl;
        logic [FW-1:0] joy_ctl;
        logic          fkey;

        if (p < 2) begin : g_kb
            assign key_ctl[3:0] = {key_bank_p1[p*10+2], key_bank_p1[p*10+3],
                                   key_bank_p1[p*10+0], key_bank_p1[p*10+1]};
            assign key_ctl[FW-1:4] = key_bank_p1[p*10+4 +: NBTN];
            assign fkey = (p == 0) ? key_bank_p1[K_F1] : key_bank_p1[K_F2];
        end else begin : g_nokb
            assign key_ctl = '0;
            assign fkey    = 1'b0;
        end

        // Joystick order is right/left/down/up; output order is down/up/right/left.
        assign joy_ctl[3:0]    = {bus.joy[16*p+1], bus.joy[16*p+0], bus.joy[16*p+3], bus.joy[16*p+2]};
        assign joy_ctl[FW-1:4] = bus.joy[16*p+4 +: NBTN];

        assign own_ctl[p]   = key_ctl | joy_ctl;
        assign joy_start[p] = bus.joy[16*p+4+NBTN];
        assign start_own[p] = joy_start[p] | key_bank_p1[K_START+p] | fkey;
        assign coin_raw[p]  = bus.joy[16*p+6+NBTN] | key_bank_p1[K_COIN+p] | fkey;
    end

    if (NPLAYER >= 2) begin : g_p2
        assign p2_ctl = own_ctl[1];
    end else begin : g_nop2
        assign p2_ctl = '0;
    end

    logic [FW-1:0]      ctl_mrg [NPLAYER];
    logic [NPLAYER-1:0] start_mrg;

    always_comb begin
        for (int p = 0; p < NPLAYER; p++)
            ctl_mrg[p] = own_ctl[p];
        start_mrg = start_own;
        if (!bus.cabinet) begin
            ctl_mrg[0]   = own_ctl[0] | p2_ctl;
            start_mrg[0] = start_own[0] | (|joy_start);
        end
    end

    logic [NPLAYER*FW-1:0] ctl_n_p2;
    logic [NPLAYER-1:0]    start_n_p2;

    // Stage 2: registered active-low controls
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctl_n_p2   <= '1;
            start_n_p2 <= '1;
        end else begin
            for (int p = 0; p < NPLAYER; p++)
                ctl_n_p2[p*FW +: FW] <= ~ctl_mrg[p];
            start_n_p2 <= ~start_mrg;
        end
    end

    logic [NPLAYER-1:0] coin_raw_p1;
    logic [NPLAYER-1:0] coin_prev_p2;
    logic [NPLAYER-1:0] coin_edge;
    logic [NPLAYER-1:0] coin_n_w;

    // Both edge registers come out of reset high so a coin still held across reset
    // must be released and pressed again before it can pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_raw_p1  <= '1;
            coin_prev_p2 <= '1;
        end else begin
            coin_raw_p1  <= coin_raw;
            coin_prev_p2 <= coin_raw_p1;
        end
    end

    assign coin_edge = coin_raw_p1 & ~coin_prev_p2;

    for (genvar c = 0; c < NPLAYER; c++) begin : g_coin
        coin_state_t state_q, state_d;
        logic [15:0] cnt_q, cnt_d;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_IDLE: begin
                    if (coin_edge[c]) begin
                        state_d = S_PULSE;
                        cnt_d   = COIN_PULSE - 16'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q != 16'd0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (COIN_GAP == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = COIN_GAP - 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q != 16'd0)
                        cnt_d = cnt_q - 16'd1;
                    else
                        state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign coin_n_w[c] = (state_q != S_PULSE);
    end

    assign bus.p_ctl_n    = ctl_n_p2;
    assign bus.start_n    = start_n_p2;
    assign bus.coin_n     = coin_n_w;
    assign bus.coin_any_n = &coin_n_w;

    // Joystick spare bits and keys for absent players/buttons are intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{bus.joy, key_bank_p1};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: vector table for joystick/cabinet mapping, scoreboard-timed
// sequences for keyboard latency, coin shaping, lockout and reset behaviour.
module tb_arcade_input_mapper;
    localparam int NP = 4;
    localparam int NB = 6;
    localparam int FW = 4 + NB;
    localparam logic [NP*FW-1:0] ALLHI = {NP*FW{1'b1}};

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    arcade_input_mapper_if #(.NPLAYER(NP), .NBTN(NB)) ifc ();

    arcade_input_mapper #(
        .NPLAYER(NP), .NBTN(NB), .COIN_PULSE(16'd4), .COIN_GAP(16'd3)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (ifc.slave)
    );

    typedef struct {
        int               due;
        logic [NP*FW-1:0] pctl;
        logic [NP-1:0]    start;
        logic [NP-1:0]    coin;
        string            name;
    } exp_t;

    typedef struct {
        logic [NP*16-1:0] joy;
        logic             cab;
        logic [NP*FW-1:0] pctl;
        logic [NP-1:0]    start;
        string            name;
    } vec_t;

    exp_t sb[$];
    vec_t vt[13];

    function automatic logic [NP*16-1:0] jb(input int p, input int b);
        logic [NP*16-1:0] v;
        v = '0;
        v[16*p+b] = 1'b1;
        return v;
    endfunction

    function automatic logic [NP*FW-1:0] ob(input int p, input int b);
        logic [NP*FW-1:0] v;
        v = '0;
        v[FW*p+b] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NP*16-1:0] coin_joy(input logic [NP-1:0] chans);
        logic [NP*16-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[16*p+6+NB] = chans[p];
        return v;
    endfunction

    task automatic check(input string nm, input logic [NP*FW-1:0] ep,
                         input logic [NP-1:0] es, input logic [NP-1:0] ec);
        n_total++;
        if (ifc.p_ctl_n === ep && ifc.start_n === es && ifc.coin_n === ec && ifc.coin_any_n === (&ec))
            n_pass++;
        else
            $display("FAIL %s @cyc %0d: got pctl=%h start=%b coin=%b any=%b, want pctl=%h start=%b coin=%b any=%b",
                     nm, cyc, ifc.p_ctl_n, ifc.start_n, ifc.coin_n, ifc.coin_any_n, ep, es, ec, &ec);
    endtask

    task automatic push(input int due, input logic [NP*FW-1:0] p, input logic [NP-1:0] s,
                        input logic [NP-1:0] c, input string nm);
        exp_t e;
        e.due = due; e.pctl = p; e.start = s; e.coin = c; e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, sb[i].pctl, sb[i].start, sb[i].coin);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic pr, input logic ex, input logic [7:0] code);
        ifc.ps2_key = {~ifc.ps2_key[10], pr, ex, code};
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expected outputs never compared, want 0", sb.size());
            n_total += sb.size();
            sb.delete();
        end
    endtask

    task automatic coin_seq(input logic [63:0] drv, input logic [63:0] low,
                            input logic [NP-1:0] chans, input int len, input string nm);
        int c;
        c = cyc;
        for (int r = 1; r <= len; r++)
            push(c + r, ALLHI, '1, low[r] ? ~chans : '1, nm);
        for (int r = 0; r < len; r++) begin
            ifc.joy = drv[r] ? coin_joy(chans) : '0;
            tick();
        end
        ifc.joy = '0;
    endtask

    initial begin
        int c;
        vt[0]  = '{'0,                  1'b1, ALLHI,                          4'hF,    "tbl_idle"};
        vt[1]  = '{jb(0,0),             1'b1, ~ob(0,2),                       4'hF,    "tbl_p1_right"};
        vt[2]  = '{jb(0,1) | jb(0,3),   1'b1, ~(ob(0,3) | ob(0,1)),           4'hF,    "tbl_p1_left_up"};
        vt[3]  = '{jb(1,2),             1'b1, ~ob(1,0),                       4'hF,    "tbl_p2_down"};
        vt[4]  = '{jb(1,3),             1'b0, ~(ob(0,1) | ob(1,1)),           4'hF,    "tbl_p2_up_upright"};
        vt[5]  = '{jb(1,3),             1'b1, ~ob(1,1),                       4'hF,    "tbl_p2_up_cocktail"};
        vt[6]  = '{jb(3,9),             1'b0, ~ob(3,9),                       4'hF,    "tbl_p4_btn5_upright"};
        vt[7]  = '{jb(1,4),             1'b0, ~(ob(0,4) | ob(1,4)),           4'hF,    "tbl_p2_btn0_upright"};
        vt[8]  = '{jb(2,10),            1'b0, ALLHI,                          4'b1010, "tbl_p3_start_upright"};
        vt[9]  = '{jb(2,10),            1'b1, ALLHI,                          4'b1011, "tbl_p3_start_cocktail"};
        vt[10] = '{jb(0,10),            1'b1, ALLHI,                          4'b1110, "tbl_p1_start"};
        vt[11] = '{jb(1,10),            1'b0, ALLHI,                          4'b1100, "tbl_p2_start_upright"};
        vt[12] = '{jb(0,4) | jb(1,5),   1'b0, ~(ob(0,4) | ob(0,5) | ob(1,5)), 4'hF,    "tbl_mixed_btn_upright"};

        // Reset held with every input active
        ifc.joy = '1; ifc.ps2_key = 11'h7FF; ifc.cabinet = 1'b0;
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("reset_hold", ALLHI, '1, '1);
        ifc.joy = '0; ifc.ps2_key = '0; ifc.cabinet = 1'b1;
        tick();
        reset_n = 1'b1;
        c = cyc;
        for (int d = 1; d <= 4; d++) push(c + d, ALLHI, '1, '1, "post_reset_idle");
        for (int d = 0; d < 4; d++) tick();

        // Joystick / cabinet table, one vector per cycle
        for (int i = 0; i < 13; i++) begin
            ifc.joy = vt[i].joy;
            ifc.cabinet = vt[i].cab;
            push(cyc + 1, vt[i].pctl, vt[i].start, '1, vt[i].name);
            tick();
        end
        ifc.joy = '0; ifc.cabinet = 1'b1;
        push(cyc + 1, ALLHI, '1, '1, "tbl_return_idle");
        tick(); tick();

        // Keyboard: extended arrow press and release on consecutive cycles
        c = cyc;
        push(c + 1, ALLHI, '1, '1, "kb_before");
        push(c + 2, ~ob(0,1), '1, '1, "kb_up_ext");
        key(1'b1, 1'b1, 8'h75); tick();
        push(c + 3, ALLHI, '1, '1, "kb_up_ext_rel");
        key(1'b0, 1'b1, 8'h75); tick(); tick(); tick();

        c = cyc;
        push(c + 2, ~ob(0,1), '1, '1, "kb_up_noext");
        key(1'b1, 1'b0, 8'h75); tick();
        push(c + 3, ALLHI, '1, '1, "kb_up_noext_rel");
        key(1'b0, 1'b0, 8'h75); tick(); tick(); tick();

        c = cyc;
        push(c + 2, ALLHI, '1, '1, "kb_1c_ext_ignored");
        key(1'b1, 1'b1, 8'h1C); tick();
        push(c + 3, ~ob(1,4), '1, '1, "kb_p2_btn0");
        key(1'b1, 1'b0, 8'h1C); tick();
        push(c + 4, ALLHI, '1, '1, "kb_p2_btn0_rel");
        key(1'b0, 1'b0, 8'h1C); tick(); tick(); tick();

        c = cyc;
        push(c + 2, ~ob(0,8), '1, '1, "kb_p1_btn4");
        key(1'b1, 1'b0, 8'h1A); tick();
        push(c + 3, ~(ob(0,8) | ob(1,1)), '1, '1, "kb_p1_btn4_p2_up");
        key(1'b1, 1'b0, 8'h2D); tick();
        push(c + 4, ~ob(1,1), '1, '1, "kb_p2_up_only");
        key(1'b0, 1'b0, 8'h1A); tick();
        push(c + 5, ALLHI, '1, '1, "kb_all_rel");
        key(1'b0, 1'b0, 8'h2D); tick(); tick(); tick();

        c = cyc;
        push(c + 2, ALLHI, 4'b1011, '1, "kb_start3");
        key(1'b1, 1'b0, 8'h26); tick();
        push(c + 3, ALLHI, '1, '1, "kb_start3_rel");
        key(1'b0, 1'b0, 8'h26); tick(); tick(); tick();

        // F1: start1 after 2 cycles, coin1 pulse one cycle later than a joystick coin
        c = cyc;
        for (int d = 1; d <= 10; d++)
            push(c + d, ALLHI, (d >= 2 && d <= 9) ? 4'b1110 : 4'hF,
                 (d >= 3 && d <= 6) ? 4'b1110 : 4'hF, "kb_f1");
        for (int r = 0; r < 10; r++) begin
            if (r == 0) key(1'b1, 1'b0, 8'h05);
            if (r == 8) key(1'b0, 1'b0, 8'h05);
            tick();
        end
        tick(); tick(); tick();
        drain();

        // Coin shaping and lockout
        coin_seq(rng(0,0), rng(2,5), 4'b0001, 12, "coin_single");
        coin_seq(rng(0,0) | rng(5,5) | rng(10,10), rng(2,5) | rng(12,15), 4'b0001, 22, "coin_lockout");
        coin_seq(rng(0,49), rng(2,5), 4'b0001, 60, "coin_held");
        coin_seq(rng(0,0), rng(2,5), 4'b1111, 12, "coin_four");
        drain();

        // Reset in the middle of a pulse with the coin held
        ifc.joy = coin_joy(4'b0001);
        tick(); tick(); tick();
        check("coin_before_reset", ALLHI, '1, 4'b1110);
        reset_n = 1'b0;
        #1;
        check("coin_async_reset", ALLHI, '1, '1);
        tick(); tick();
        reset_n = 1'b1;
        c = cyc;
        for (int d = 1; d <= 10; d++) push(c + d, ALLHI, '1, '1, "coin_held_after_reset");
        for (int d = 0; d < 10; d++) tick();
        ifc.joy = '0;
        tick(); tick(); tick();
        coin_seq(rng(0,0), rng(2,5), 4'b0001, 12, "coin_rearmed");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
